// File: rtl/mult_rs.sv
// Reservation station feeding the pipelined multiplier: captures operands from
// dispatch or CDB wakeup, issues the oldest ready op, and honours branch squash/resolve.
module mult_rs #(
    parameter int RS_SZ  = 4,
    parameter int PREG_W = 6,
    parameter int BM_W   = 4,
    parameter int XLEN   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [1:0]        disp_func,
    input  logic [PREG_W-1:0] disp_src1_tag,
    input  logic [PREG_W-1:0] disp_src2_tag,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    input  logic [XLEN-1:0]   disp_src1_val,
    input  logic [XLEN-1:0]   disp_src2_val,
    input  logic [PREG_W-1:0] disp_dest,
    input  logic [BM_W-1:0]   disp_bm,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]   cdb_value,
    input  logic [BM_W-1:0]   b_mm_resolve,
    input  logic              b_mm_mispred,
    input  logic              fu_free,
    output logic              issue_valid,
    output logic [1:0]        issue_func,
    output logic [XLEN-1:0]   issue_src1,
    output logic [XLEN-1:0]   issue_src2,
    output logic [PREG_W-1:0] issue_dest,
    output logic [BM_W-1:0]   issue_bm
);
    logic [RS_SZ-1:0]             valid_q, valid_d;
    logic [RS_SZ-1:0][1:0]        func_q, func_d;
    logic [RS_SZ-1:0][PREG_W-1:0] t1_q, t1_d, t2_q, t2_d, dest_q, dest_d;
    logic [RS_SZ-1:0]             r1_q, r1_d, r2_q, r2_d;
    logic [RS_SZ-1:0][XLEN-1:0]   v1_q, v1_d, v2_q, v2_d;
    logic [RS_SZ-1:0][BM_W-1:0]   bm_q, bm_d;
    // older_q[j][i] set means entry j was dispatched before entry i
    logic [RS_SZ-1:0][RS_SZ-1:0]  older_q, older_d;

    logic [RS_SZ-1:0] squash, rdy, sel_oh, alloc_oh;
    logic             disp_ok, issue_fire, found;

    assign rs_full = &valid_q;

    always_comb begin
        for (int i = 0; i < RS_SZ; i++) begin
            squash[i] = b_mm_mispred && ((bm_q[i] & b_mm_resolve) != '0);
            rdy[i]    = valid_q[i] && r1_q[i] && r2_q[i] && !squash[i];
        end
    end

    // Oldest ready entry wins: drop any candidate with an older ready peer.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            sel_oh[i] = rdy[i];
            for (int j = 0; j < RS_SZ; j++)
                if (j != i && rdy[j] && older_q[j][i]) sel_oh[i] = 1'b0;
        end
    end

    always_comb begin
        issue_func = '0;
        issue_src1 = '0;
        issue_src2 = '0;
        issue_dest = '0;
        issue_bm   = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (sel_oh[i]) begin
                issue_func = issue_func | func_q[i];
                issue_src1 = issue_src1 | v1_q[i];
                issue_src2 = issue_src2 | v2_q[i];
                issue_dest = issue_dest | dest_q[i];
                issue_bm   = issue_bm | (bm_q[i] & ~b_mm_resolve);
            end
        end
    end

    assign issue_valid = |sel_oh;
    assign issue_fire  = issue_valid && fu_free;
    assign disp_ok     = disp_valid && !rs_full &&
                         !(b_mm_mispred && ((disp_bm & b_mm_resolve) != '0));

    // Allocation looks only at registered validity, so a slot freed by issue waits a cycle.
    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (disp_ok && !valid_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        func_d  = func_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        dest_d  = dest_q;
        bm_d    = bm_q;
        older_d = older_q;
        for (int i = 0; i < RS_SZ; i++) begin
            if (cdb_valid && valid_q[i] && !r1_q[i] && t1_q[i] == cdb_tag) begin
                r1_d[i] = 1'b1;
                v1_d[i] = cdb_value;
            end
            if (cdb_valid && valid_q[i] && !r2_q[i] && t2_q[i] == cdb_tag) begin
                r2_d[i] = 1'b1;
                v2_d[i] = cdb_value;
            end
            bm_d[i] = bm_q[i] & ~b_mm_resolve;
            if (squash[i] || (issue_fire && sel_oh[i])) valid_d[i] = 1'b0;
            if (alloc_oh[i]) begin
                valid_d[i] = 1'b1;
                func_d[i]  = disp_func;
                t1_d[i]    = disp_src1_tag;
                t2_d[i]    = disp_src2_tag;
                r1_d[i]    = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
                r2_d[i]    = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_tag);
                v1_d[i]    = disp_src1_rdy ? disp_src1_val : cdb_value;
                v2_d[i]    = disp_src2_rdy ? disp_src2_val : cdb_value;
                dest_d[i]  = disp_dest;
                bm_d[i]    = disp_bm & ~b_mm_resolve;
                for (int j = 0; j < RS_SZ; j++) begin
                    older_d[i][j] = 1'b0;
                    if (j != i) older_d[j][i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            func_q  <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            dest_q  <= '0;
            bm_q    <= '0;
            older_q <= '0;
        end else begin
            valid_q <= valid_d;
            func_q  <= func_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            dest_q  <= dest_d;
            bm_q    <= bm_d;
            older_q <= older_d;
        end
    end
endmodule

// File: tb/tb_mult_rs.sv
// Bench for mult_rs: directed scenarios plus random traffic, all cycles checked
// against an age-ordered queue model of the station.
module tb_mult_rs;
    localparam int RS_SZ = 4, PREG_W = 6, BM_W = 4, XLEN = 32;

    logic              clock = 0, reset = 0;
    logic              disp_valid, disp_src1_rdy, disp_src2_rdy;
    logic [1:0]        disp_func;
    logic [PREG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dest, cdb_tag;
    logic [XLEN-1:0]   disp_src1_val, disp_src2_val, cdb_value;
    logic [BM_W-1:0]   disp_bm, b_mm_resolve;
    logic              cdb_valid, b_mm_mispred, fu_free, rs_full, issue_valid;
    logic [1:0]        issue_func;
    logic [XLEN-1:0]   issue_src1, issue_src2;
    logic [PREG_W-1:0] issue_dest;
    logic [BM_W-1:0]   issue_bm;

    mult_rs #(.RS_SZ(RS_SZ), .PREG_W(PREG_W), .BM_W(BM_W), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_func(disp_func),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_dest(disp_dest), .disp_bm(disp_bm), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred), .fu_free(fu_free),
        .issue_valid(issue_valid), .issue_func(issue_func), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .issue_dest(issue_dest), .issue_bm(issue_bm)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]        func;
        logic              r1, r2;
        logic [PREG_W-1:0] t1, t2, dest;
        logic [XLEN-1:0]   v1, v2;
        logic [BM_W-1:0]   bm;
    } ent_t;

    ent_t mq[$];   // valid ops, oldest first
    int   errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit killed(input logic [BM_W-1:0] bm);
        return b_mm_mispred && ((bm & b_mm_resolve) != '0);
    endfunction

    // Compare against the model, then advance the model across the next edge.
    task automatic tick();
        int   sel;
        bit   full;
        ent_t nq[$];
        ent_t e;
        #1;
        sel = -1;
        foreach (mq[i])
            if (sel < 0 && mq[i].r1 && mq[i].r2 && !killed(mq[i].bm)) sel = i;
        chk("rs_full", rs_full, mq.size() == RS_SZ);
        chk("issue_valid", issue_valid, sel >= 0);
        if (sel >= 0) begin
            chk("issue_func", issue_func, mq[sel].func);
            chk("issue_src1", issue_src1, mq[sel].v1);
            chk("issue_src2", issue_src2, mq[sel].v2);
            chk("issue_dest", issue_dest, mq[sel].dest);
            chk("issue_bm", issue_bm, mq[sel].bm & ~b_mm_resolve);
        end
        @(posedge clock);
        if (!reset) mq.delete();
        else begin
            full = (mq.size() == RS_SZ);
            foreach (mq[i]) begin
                e = mq[i];
                if (killed(e.bm) || (i == sel && fu_free)) continue;
                if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.v1 = cdb_value; end
                if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.v2 = cdb_value; end
                e.bm = e.bm & ~b_mm_resolve;
                nq.push_back(e);
            end
            if (disp_valid && !full && !killed(disp_bm)) begin
                e.func = disp_func; e.dest = disp_dest; e.bm = disp_bm & ~b_mm_resolve;
                e.t1 = disp_src1_tag; e.t2 = disp_src2_tag;
                e.r1 = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
                e.r2 = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_tag);
                e.v1 = disp_src1_rdy ? disp_src1_val : cdb_value;
                e.v2 = disp_src2_rdy ? disp_src2_val : cdb_value;
                nq.push_back(e);
            end
            mq = nq;
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic ff);
        disp_valid = 0; disp_func = 0; disp_src1_tag = 0; disp_src2_tag = 0;
        disp_src1_rdy = 0; disp_src2_rdy = 0; disp_src1_val = 0; disp_src2_val = 0;
        disp_dest = 0; disp_bm = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        b_mm_resolve = 0; b_mm_mispred = 0; fu_free = ff; reset = 1;
    endtask

    task automatic disp(input logic [1:0] f, input logic [PREG_W-1:0] t2, input logic r2,
                        input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                        input logic [PREG_W-1:0] d, input logic [BM_W-1:0] bm);
        disp_valid = 1; disp_func = f; disp_src1_tag = 1; disp_src1_rdy = 1;
        disp_src1_val = v1; disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_val = v2;
        disp_dest = d; disp_bm = bm;
    endtask

    initial begin
        idle(1'b1);
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_valid", issue_valid, 0);
        chk("rst_full", rs_full, 0);
        chk("rst_fields", {issue_func, issue_src1, issue_dest, issue_bm}, 0);
        chk("rst_src2", issue_src2, 0);
        idle(1'b1);
        tick();

        // Simple ready op issues the following cycle
        disp(0, 2, 1, 5, 7, 12, 0); tick();
        idle(1'b1); #1;
        chk("t1_src1", issue_src1, 5);
        chk("t1_src2", issue_src2, 7);
        chk("t1_dest", issue_dest, 12);
        tick(); tick();

        // Same-cycle CDB capture at dispatch
        disp(0, 9, 0, 3, 0, 13, 0); cdb_valid = 1; cdb_tag = 9; cdb_value = 32'h10; tick();
        idle(1'b1); #1;
        chk("byp_src2", issue_src2, 32'h10);
        tick();

        // Fill, drop a fifth dispatch, then drain in order
        for (int k = 0; k < 5; k++) begin idle(1'b0); disp(1, 2, 1, k, k, 6'(20 + k), 0); tick(); end
        idle(1'b0); #1;
        chk("full", rs_full, 1);
        for (int k = 0; k < 4; k++) begin idle(1'b1); #1; chk("drain_dest", issue_dest, 20 + k); tick(); end
        idle(1'b1); #1;
        chk("drain_empty", {rs_full, issue_valid}, 0);

        // Mispredict squashes the selected entry combinationally
        idle(1'b0); disp(0, 2, 1, 1, 1, 30, 4'b0010); tick();
        idle(1'b0); disp(0, 2, 1, 2, 2, 31, 4'b0000); tick();
        idle(1'b1); b_mm_resolve = 4'b0010; b_mm_mispred = 1; #1;
        chk("sq_dest", issue_dest, 31);
        tick();
        idle(1'b1); #1;
        chk("sq_gone", issue_valid, 0);
        tick();

        // Correct resolve clears the bit in flight and in storage
        idle(1'b0); disp(2, 2, 1, 4, 4, 40, 4'b0011); tick();
        idle(1'b0); b_mm_resolve = 4'b0001; #1;
        chk("res_bm", issue_bm, 4'b0010);
        tick();
        idle(1'b1); #1;
        chk("res_bm_stored", issue_bm, 4'b0010);
        tick();

        // Reset with live entries
        for (int k = 0; k < 3; k++) begin idle(1'b0); disp(3, 2, 1, k, k, 6'(50 + k), 0); tick(); end
        idle(1'b0); reset = 0; tick();
        idle(1'b1); #1;
        chk("rst2", {issue_valid, rs_full}, 0);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle(($urandom % 10) < 7);
            reset = ($urandom % 250) != 0;
            disp_valid = ($urandom % 2);
            disp_func = 2'($urandom);
            disp_src1_tag = 6'($urandom % 8); disp_src2_tag = 6'($urandom % 8);
            disp_src1_rdy = ($urandom % 3) != 0; disp_src2_rdy = ($urandom % 3) != 0;
            disp_src1_val = $urandom; disp_src2_val = $urandom;
            disp_dest = 6'($urandom); disp_bm = 4'($urandom % 16);
            cdb_valid = ($urandom % 5) < 2; cdb_tag = 6'($urandom % 8); cdb_value = $urandom;
            if (($urandom % 8) == 0) begin
                b_mm_resolve = 4'(1 << ($urandom % 4));
                b_mm_mispred = $urandom % 2;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mult_rs.md
# mult_rs

Reservation station for the pipelined multiplier. Holds up to `RS_SZ` dispatched multiply ops and captures operand values from dispatch or from CDB wakeup. Issues the oldest ready op into the multiplier's first stage under its `fu_free` backpressure. Tracks branch masks so squashed ops never reach the multiplier.

## Interface
Parameters:
- `RS_SZ`, 4: number of entries.
- `PREG_W`, 6: physical register tag width.
- `BM_W`, 4: branch mask width.
- `XLEN`, 32: operand width.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. Asserted when 0; sampled on `clock`.
- `disp_valid` in 1: dispatch request.
- `disp_func` in 2: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- `disp_src1_tag`, `disp_src2_tag` in `PREG_W`: source tags.
- `disp_src1_rdy`, `disp_src2_rdy` in 1: value supplied at dispatch.
- `disp_src1_val`, `disp_src2_val` in `XLEN`: source values, meaningful when the matching `rdy` is 1.
- `disp_dest` in `PREG_W`: destination tag.
- `disp_bm` in `BM_W`: branch mask.
- `rs_full` out 1: all entries valid, from registered state.
- `cdb_valid` in 1, `cdb_tag` in `PREG_W`, `cdb_value` in `XLEN`: wakeup broadcast.
- `b_mm_resolve` in `BM_W`: one-hot resolving branch, or 0.
- `b_mm_mispred` in 1: the resolving branch mispredicted.
- `fu_free` in 1: multiplier stage 0 accepts this cycle.
- `issue_valid` out 1, `issue_func` out 2, `issue_src1`/`issue_src2` out `XLEN`, `issue_dest` out `PREG_W`, `issue_bm` out `BM_W`: packet to the multiplier, combinational from entry state.

## Operation
- Entry fields: valid, func, per-source tag/rdy/val, dest, bm, age.
- An entry is ready when valid and both sources rdy.
- **Allocation:** when `disp_valid` and not `rs_full`, write the lowest-index invalid entry. `disp_valid` while `rs_full` is dropped with no state change.
- **Wakeup:** on `cdb_valid`, every valid entry source with rdy=0 and tag==`cdb_tag` sets rdy=1 and val=`cdb_value`.
  - A dispatching source with rdy=0 and tag==`cdb_tag` in the same cycle is written rdy=1 with `cdb_value`.
- **Age:** an age matrix, or an equivalent scheme, orders entries by dispatch cycle. Selection picks the oldest ready entry that is not being squashed.
- **Issue:** `issue_valid`=1 when a selected entry exists. The entry is invalidated at the edge when `issue_valid && fu_free`. `issue_*` holds the selected entry's fields.
- **Branch resolve** (`b_mm_resolve` != 0), with R = resolve:
  - Mispredict: entries with bm&R != 0 are invalidated at the edge. Such entries are excluded from selection the same cycle, so `issue_valid` falls combinationally. A dispatch with `disp_bm`&R != 0 is dropped.
  - Correct: bit R is cleared in all entries and in the dispatching bm. `issue_bm` = stored bm & ~R, so the multiplier never holds a stale bit.
- **Simultaneous events:** issue, dispatch, wakeup, and resolve may all occur in one cycle and are all applied. A slot freed by issue is not reallocated the same cycle.

## Timing
- Reset (`reset`=0 at an edge): all entries invalid. The next cycle shows `rs_full`=0, `issue_valid`=0, and other `issue_*`=0.
- Reset mid-operation drops all contents with no issue.
- Dispatch with both sources ready at cycle t gives earliest `issue_valid` at t+1.
- A CDB wakeup at t makes the entry eligible at t+1. There is no same-cycle bypass to issue.
- Back-to-back issue one op per cycle while `fu_free`=1.
- `fu_free`=0 holds the selected entry, and `issue_*` stays stable unless an older entry becomes ready or a squash or resolve applies.
- `rs_full` reflects state after the previous edge.

## Test plan
- Reset, then dispatch MUL src1=5, src2=7 both ready, dest=12, bm=0 at cycle 1, with `fu_free`=1 → cycle 2: `issue_valid`=1, src1=5, src2=7, dest=12. Cycle 3: `issue_valid`=0.
- Dispatch op A with src2 tag 9 not ready, then op B fully ready. CDB tag 9 value 0x10 at cycle 4 → B issues first. A issues at cycle 5 with src2=0x10. Repeat with the CDB broadcast in the same cycle as A's dispatch → A is ready the following cycle.
- Fill 4 entries with `fu_free`=0 → `rs_full`=1. A 5th dispatch is dropped. Raise `fu_free` → four issues in dispatch order over 4 consecutive cycles, then `rs_full`=0.
- Entries with bm=0b0010 and 0b0000. `b_mm_resolve`=0b0010, `b_mm_mispred`=1 in the cycle the first is selected → `issue_valid` deasserts (or switches to the bm=0 entry) the same cycle. The masked entry never issues.
- Entry with bm=0b0011 selected while `b_mm_resolve`=0b0001, `b_mm_mispred`=0 → `issue_bm`=0b0010, and the stored bm becomes 0b0010.
- Assert `reset`=0 with 3 valid entries → `issue_valid`=0 and `rs_full`=0 next cycle. No stale issue after reset is released.
